// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FPU command scheduler.
//   - unit indices (bit position of each unit in fpu_valid_in)
//   - packed command layout and the queue entry (command + requester id)
//   - response error encodings
//   - scheduler FSM states
package fpu_sched_pkg;

  localparam logic [3:0] UNIT_FCLASS = 4'd0;
  localparam logic [3:0] UNIT_SGNJ   = 4'd1;
  localparam logic [3:0] UNIT_CMP    = 4'd2;
  localparam logic [3:0] UNIT_MINMAX = 4'd3;
  localparam logic [3:0] UNIT_I2F    = 4'd4;
  localparam logic [3:0] UNIT_F2I    = 4'd5;
  localparam logic [3:0] UNIT_ADDSUB = 4'd6;
  localparam logic [3:0] UNIT_MUL    = 4'd7;
  localparam logic [3:0] UNIT_FMA    = 4'd8;
  localparam logic [3:0] UNIT_DIV    = 4'd9;
  localparam logic [3:0] UNIT_SQRT   = 4'd10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [3:0]  unit;
    logic [1:0]  op;
    logic [2:0]  frm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } fpu_cmd_t;

  localparam int CMD_W = $bits(fpu_cmd_t);

  typedef struct packed {
    logic     src;
    fpu_cmd_t cmd;
  } q_entry_t;

  localparam int ENTRY_W = $bits(q_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_state_t;

  // Divide and square root finish on a done pulse instead of in the issue cycle.
  function automatic logic is_multicycle(input logic [3:0] unit);
    return (unit == UNIT_DIV) || (unit == UNIT_SQRT);
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous FIFO holding scheduler commands.
//   clk, rst        : clock, synchronous active-high reset (flushes contents)
//   push, wdata     : write request and data (ignored when full unless popping)
//   pop, rdata      : read request; rdata shows the head entry (first-word fall-through)
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module fpu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot being written, so push+pop is fine even when full.
  assign do_push = push & (~full | do_pop);

  // Head is read asynchronously: the scheduler loads it into its command
  // register in the same cycle it pops.
  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/fpu_cmd_scheduler.sv
// Command scheduler in front of the FPU datapath.
//   req_valid/req_ready/req_cmd : two requesters (0 wishbone, 1 logic analyzer),
//                                 round-robin arbitrated into a command queue
//   fpu_valid_in/op/frm/a/b/c   : one-hot unit enable and operands to the datapath
//   fpu_result/exc/illegal      : datapath result, captured in the issue cycle
//   fpu_div_done/fpu_sqrt_done  : completion pulses of the multi-cycle units
//   rsp_*                       : one-entry response buffer, valid/ready handshake
//   busy, q_count               : activity and queue occupancy status
module fpu_cmd_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64,
  parameter int NUM_UNITS = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][CMD_W-1:0]     req_cmd,
  output logic [NUM_UNITS-1:0]      fpu_valid_in,
  output logic [1:0]                fpu_op,
  output logic [2:0]                fpu_frm,
  output logic [31:0]               fpu_a,
  output logic [31:0]               fpu_b,
  output logic [31:0]               fpu_c,
  input  logic [31:0]               fpu_result,
  input  logic [4:0]                fpu_exc,
  input  logic                      fpu_illegal,
  input  logic                      fpu_div_done,
  input  logic                      fpu_sqrt_done,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic [4:0]                rsp_exc,
  output logic                      rsp_src,
  output logic [1:0]                rsp_err,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    q_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The counter clears on ISSUE and the timeout fires on the WAIT cycle whose
  // edge would take it to TIMEOUT-1, so RESP lands exactly TIMEOUT cycles
  // after the ISSUE cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  // ---------------- arbitration ----------------
  logic       prio_reg;      // requester that wins when both are valid
  logic [1:0] grant;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       push_src;
  q_entry_t   push_entry;
  q_entry_t   head_entry;

  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) grant[prio_reg] = 1'b1;
    else                    grant = req_valid;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = grant[gi] & ~fifo_full & ~rst;
  end

  assign fifo_push  = |(req_valid & req_ready);
  assign push_src   = req_ready[1];
  assign push_entry = {push_src, req_cmd[push_src]};

  always_ff @(posedge clk) begin
    if (rst)            prio_reg <= 1'b0;
    else if (fifo_push) prio_reg <= ~push_src;
  end

  fpu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  // ---------------- issue FSM ----------------
  sched_state_t state_reg, state_next;
  q_entry_t     cmd_reg, cmd_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [31:0]  rsp_data_reg, rsp_data_next;
  logic [4:0]   rsp_exc_reg, rsp_exc_next;
  logic [1:0]   rsp_err_reg, rsp_err_next;
  logic         done_match;

  assign done_match = ((cmd_reg.cmd.unit == UNIT_DIV)  & fpu_div_done) |
                      ((cmd_reg.cmd.unit == UNIT_SQRT) & fpu_sqrt_done);

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    rsp_data_next = rsp_data_reg;
    rsp_exc_next  = rsp_exc_reg;
    rsp_err_next  = rsp_err_reg;
    fifo_pop      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !rsp_valid) begin
          fifo_pop = 1'b1;
          cmd_next = head_entry;
          if (head_entry.cmd.unit > UNIT_SQRT) begin
            // No such unit: answer immediately without touching the datapath.
            rsp_data_next = '0;
            rsp_exc_next  = '0;
            rsp_err_next  = ERR_ILLEGAL;
            state_next    = ST_RESP;
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (is_multicycle(cmd_reg.cmd.unit)) begin
          tmo_cnt_next = '0;
          state_next   = ST_WAIT;
        end else begin
          rsp_exc_next = fpu_exc;
          if (fpu_illegal) begin
            rsp_data_next = '0;
            rsp_err_next  = ERR_ILLEGAL;
          end else begin
            rsp_data_next = fpu_result;
            rsp_err_next  = ERR_OK;
          end
          state_next = ST_RESP;
        end
      end
      ST_WAIT: begin
        // A done pulse wins over a timeout falling in the same cycle.
        if (done_match) begin
          rsp_data_next = fpu_result;
          rsp_exc_next  = fpu_exc;
          rsp_err_next  = ERR_OK;
          state_next    = ST_RESP;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          rsp_data_next = '0;
          rsp_exc_next  = '0;
          rsp_err_next  = ERR_TIMEOUT;
          state_next    = ST_RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      tmo_cnt_reg  <= '0;
      rsp_data_reg <= '0;
      rsp_exc_reg  <= '0;
      rsp_err_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      rsp_data_reg <= rsp_data_next;
      rsp_exc_reg  <= rsp_exc_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    fpu_valid_in = '0;
    if (state_reg == ST_ISSUE && cmd_reg.cmd.unit <= UNIT_SQRT)
      fpu_valid_in = NUM_UNITS'(1) << cmd_reg.cmd.unit;
  end

  assign fpu_op    = cmd_reg.cmd.op;
  assign fpu_frm   = cmd_reg.cmd.frm;
  assign fpu_a     = cmd_reg.cmd.a;
  assign fpu_b     = cmd_reg.cmd.b;
  assign fpu_c     = cmd_reg.cmd.c;

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_exc   = rsp_exc_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_src   = cmd_reg.src;
  assign busy      = ~fifo_empty | (state_reg != ST_IDLE) | rsp_valid;

endmodule

// File: tb/tb_fpu_cmd_scheduler.sv
// Directed testbench for fpu_cmd_scheduler (DEPTH=4, TIMEOUT=64).
module tb_fpu_cmd_scheduler;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][104:0] req_cmd;
  logic [10:0]       fpu_valid_in;
  logic [1:0]        fpu_op;
  logic [2:0]        fpu_frm;
  logic [31:0]       fpu_a, fpu_b, fpu_c;
  logic [31:0]       fpu_result;
  logic [4:0]        fpu_exc;
  logic              fpu_illegal;
  logic              fpu_div_done;
  logic              fpu_sqrt_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_exc;
  logic              rsp_src;
  logic [1:0]        rsp_err;
  logic              busy;
  logic [2:0]        q_count;

  // Datapath model: fixed result, or echo operand a so responses identify commands.
  logic        echo_mode;
  logic [31:0] res_val;
  assign fpu_result = echo_mode ? fpu_a : res_val;

  int          errors = 0;
  int          checks = 0;
  int          n, k, pushes, n0, n1;
  logic [1:0]  g;
  logic [32:0] e;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_cmd_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .fpu_valid_in  (fpu_valid_in),
    .fpu_op        (fpu_op),
    .fpu_frm       (fpu_frm),
    .fpu_a         (fpu_a),
    .fpu_b         (fpu_b),
    .fpu_c         (fpu_c),
    .fpu_result    (fpu_result),
    .fpu_exc       (fpu_exc),
    .fpu_illegal   (fpu_illegal),
    .fpu_div_done  (fpu_div_done),
    .fpu_sqrt_done (fpu_sqrt_done),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_exc       (rsp_exc),
    .rsp_src       (rsp_src),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .q_count       (q_count)
  );

  function automatic logic [104:0] mk(input logic [3:0] u, input logic [1:0] op,
                                      input logic [2:0] frm, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] c);
    return {u, op, frm, a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_cmd = '0; fpu_exc = '0; fpu_illegal = 1'b0;
    fpu_div_done = 1'b0; fpu_sqrt_done = 1'b0; rsp_ready = 1'b0;
    echo_mode = 1'b0; res_val = '0;
    repeat (3) tick();

    // ---- reset state ----
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fpu_valid", fpu_valid_in, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_busy", busy, 0);
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    // ---- add from requester 0 ----
    rsp_ready = 1'b1; res_val = 32'h4040_0000; fpu_exc = 5'h01;
    req_cmd[0] = mk(4'd6, 2'd0, 3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h0);
    req_valid = 2'b01;
    #1;
    chk("add_req_ready", req_ready, 2'b01);
    tick();                                   // push
    req_valid = 2'b00;
    chk("add_q_count", q_count, 1);
    chk("add_no_rsp_early", rsp_valid, 0);
    tick();                                   // pop -> ISSUE
    chk("add_valid_in", fpu_valid_in, 11'h040);
    chk("add_fpu_a", fpu_a, 32'h3F80_0000);
    chk("add_rsp_not_yet", rsp_valid, 0);
    tick();                                   // 2 cycles after pop
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_data", rsp_data, 32'h4040_0000);
    chk("add_rsp_src", rsp_src, 0);
    chk("add_rsp_err", rsp_err, 2'b00);
    chk("add_rsp_exc", rsp_exc, 5'h01);
    tick();
    chk("add_rsp_done", rsp_valid, 0);
    chk("add_idle_busy", busy, 0);

    // ---- divide from requester 1, done after ~30 cycles ----
    fpu_exc = 5'h00; res_val = 32'hDEAD_BEEF;
    req_cmd[1] = mk(4'd9, 2'd0, 3'd0, 32'h40C0_0000, 32'h4000_0000, 32'h0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    chk("div_valid_in", fpu_valid_in, 11'h200);
    tick();
    chk("div_valid_in_1cyc", fpu_valid_in, 11'h000);
    fpu_sqrt_done = 1'b1;                     // wrong unit, must be ignored
    tick();
    fpu_sqrt_done = 1'b0;
    chk("div_ignore_sqrt_done", rsp_valid, 0);
    chk("div_fpu_a_stable", fpu_a, 32'h40C0_0000);
    repeat (27) tick();
    fpu_div_done = 1'b1; res_val = 32'h4040_0000;
    tick();
    fpu_div_done = 1'b0;
    chk("div_rsp_valid", rsp_valid, 1);
    chk("div_rsp_data", rsp_data, 32'h4040_0000);
    chk("div_rsp_src", rsp_src, 1);
    chk("div_rsp_err", rsp_err, 2'b00);
    tick();

    // ---- divide timeout ----
    fpu_exc = 5'h10; res_val = 32'h1234_5678;
    req_cmd[0] = mk(4'd9, 2'd0, 3'd0, 32'h3F80_0000, 32'h0, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("tmo_issue", fpu_valid_in, 11'h200);
    n = 0;
    while (n < 200 && !rsp_valid) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 64);
    chk("tmo_rsp_err", rsp_err, 2'b10);
    chk("tmo_rsp_data", rsp_data, 0);
    chk("tmo_rsp_exc", rsp_exc, 0);
    tick();

    // ---- done pulse in the timeout cycle wins ----
    fpu_exc = 5'h00;
    req_cmd[1] = mk(4'd9, 2'd0, 3'd0, 32'h4100_0000, 32'h3F80_0000, 32'h0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    chk("race_issue", fpu_valid_in, 11'h200);
    repeat (63) tick();
    chk("race_pre", rsp_valid, 0);
    fpu_div_done = 1'b1; res_val = 32'h4100_0000;
    tick();
    fpu_div_done = 1'b0;
    chk("race_rsp_valid", rsp_valid, 1);
    chk("race_rsp_err", rsp_err, 2'b00);
    chk("race_rsp_data", rsp_data, 32'h4100_0000);
    tick();

    // ---- round-robin with both requesters valid ----
    echo_mode = 1'b1; rsp_ready = 1'b0;
    n0 = 0; n1 = 0; pushes = 0;
    req_cmd[0] = mk(4'd6, 2'd0, 3'd0, 32'hA000_0000, 32'h0, 32'h0);
    req_cmd[1] = mk(4'd6, 2'd0, 3'd0, 32'hB000_0000, 32'h0, 32'h0);
    req_valid = 2'b11;
    for (int cyc = 0; cyc < 50 && pushes < 4; cyc++) begin
      #1;
      g = req_ready;
      if (g != 2'b00) begin
        chk("rr_grant", g, (pushes % 2 == 0) ? 2'b01 : 2'b10);
        if (g[0]) begin exp_q.push_back({1'b0, 32'hA000_0000 + n0}); n0++; end
        else      begin exp_q.push_back({1'b1, 32'hB000_0000 + n1}); n1++; end
        pushes++;
      end
      tick();
      req_cmd[0] = mk(4'd6, 2'd0, 3'd0, 32'hA000_0000 + n0, 32'h0, 32'h0);
      req_cmd[1] = mk(4'd6, 2'd0, 3'd0, 32'hB000_0000 + n1, 32'h0, 32'h0);
    end
    req_valid = 2'b00;
    chk("rr_pushes", pushes, 4);
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        chk("rr_rsp_data", rsp_data, e[31:0]);
        chk("rr_rsp_src", rsp_src, e[32]);
      end
      tick();
    end
    chk("rr_drained", exp_q.size(), 0);
    repeat (3) tick();

    // ---- back-pressure: DEPTH+2 push attempts with rsp_ready low ----
    rsp_ready = 1'b0; k = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      req_cmd[0] = mk(4'd6, 2'd0, 3'd0, 32'hC000_0000 + k, 32'h0, 32'h0);
      req_valid = 2'b01;
      #1;
      if (req_ready[0]) begin
        exp_q.push_back({1'b0, 32'hC000_0000 + k});
        k++;
      end
      tick();
    end
    #1;
    chk("bp_accepted", k, 5);
    chk("bp_ready_full", req_ready, 2'b00);
    chk("bp_q_count", q_count, 4);
    chk("bp_rsp_held", rsp_valid, 1);
    chk("bp_rsp_head", rsp_data, 32'hC000_0000);
    repeat (3) tick();
    chk("bp_q_count_hold", q_count, 4);
    chk("bp_rsp_stable", rsp_data, 32'hC000_0000);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (rsp_valid) begin
        e = exp_q.pop_front();
        chk("bp_rsp_data", rsp_data, e[31:0]);
      end
      tick();
    end
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_q_empty", q_count, 0);
    repeat (3) tick();

    // ---- unit 12: illegal, no datapath enable ----
    req_cmd[0] = mk(4'd12, 2'd0, 3'd0, 32'h5555_5555, 32'h0, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("bad_unit_valid_in0", fpu_valid_in, 0);
    tick();
    chk("bad_unit_valid_in1", fpu_valid_in, 0);
    chk("bad_unit_rsp_valid", rsp_valid, 1);
    chk("bad_unit_rsp_err", rsp_err, 2'b01);
    chk("bad_unit_rsp_data", rsp_data, 0);
    tick();

    // ---- sign-inject with datapath illegal ----
    fpu_illegal = 1'b1;
    req_cmd[0] = mk(4'd1, 2'd3, 3'd0, 32'h7777_7777, 32'h0, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("sgnj_valid_in", fpu_valid_in, 11'h002);
    chk("sgnj_op", fpu_op, 2'd3);
    tick();
    fpu_illegal = 1'b0;
    chk("sgnj_rsp_valid", rsp_valid, 1);
    chk("sgnj_rsp_err", rsp_err, 2'b01);
    chk("sgnj_rsp_data", rsp_data, 0);
    tick();

    // ---- reset while waiting for sqrt ----
    req_cmd[0] = mk(4'd10, 2'd0, 3'd0, 32'h4080_0000, 32'h0, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("rstw_issue", fpu_valid_in, 11'h400);
    tick();
    req_cmd[0] = mk(4'd6, 2'd0, 3'd0, 32'h1, 32'h2, 32'h0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("rstw_q_count_pre", q_count, 1);
    rst = 1'b1;
    tick();
    chk("rstw_busy", busy, 0);
    chk("rstw_q_count", q_count, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_valid_in", fpu_valid_in, 0);
    rst = 1'b0;
    fpu_sqrt_done = 1'b1;
    tick();
    fpu_sqrt_done = 1'b0;
    chk("rstw_late_done", rsp_valid, 0);
    repeat (3) tick();
    chk("rstw_no_rsp", rsp_valid, 0);
    chk("rstw_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_cmd_scheduler.md
Name: fpu_cmd_scheduler

Overview:
Command scheduler in front of the FPU datapath. Two requesters (0 = wishbone, 1 = logic analyzer) submit packed FPU commands, which are arbitrated round-robin into a small command queue. Commands issue one at a time to the datapath, including the multi-cycle divide and square-root units, and each result is returned through a one-entry response buffer with a valid/ready handshake.

Parameters:
DEPTH, 4, command queue entries; power of 2, at least 2
TIMEOUT, 64, maximum cycles to wait for a div/sqrt done pulse
NUM_UNITS, 11, number of FPU units; one-hot valid width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester command valid
req_ready  out  2  per-requester accept; a transfer occurs when valid and ready are both high
req_cmd  in  2x105  packed per requester: {unit[3:0], op[1:0], frm[2:0], a[31:0], b[31:0], c[31:0]}
fpu_valid_in  out  11  one-hot unit enable: sqrt, div, fma, mul, add-sub, f2i, i2f, min-max, cmp, sign-inj, f-class
fpu_op  out  2  operation select to the datapath
fpu_frm  out  3  rounding mode to the datapath
fpu_a / fpu_b / fpu_c  out  32 each  operands to the datapath
fpu_result  in  32  datapath result
fpu_exc  in  5  datapath exception flags
fpu_illegal  in  1  datapath illegal-op indication
fpu_div_done  in  1  divider out_valid pulse
fpu_sqrt_done  in  1  sqrt out_valid pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  32  result
rsp_exc  out  5  exception flags
rsp_src  out  1  requester id of the command
rsp_err  out  2  00 ok, 01 illegal, 10 timeout
busy  out  1  queue non-empty, or FSM not IDLE, or rsp_valid high
q_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset: all outputs 0, queue empty, FSM IDLE, round-robin pointer set to 0. req_ready is 0 while rst is high.
- Arbitration: when both requesters are valid, grant goes to the requester not granted last. req_ready[i] = grant[i] & ~full. At most one push per cycle.
- Queue: FIFO ordering.
  - Push and pop in the same cycle leave the count unchanged; this is legal even when the queue is full.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the queue is non-empty and rsp_valid is 0, pop the head into the command register and go to ISSUE.
  - If unit > 10, skip ISSUE: load a response with data 0, exc 0, err 01, and go to RESP.
- ISSUE: exactly one cycle.
  - fpu_valid_in = 1 << unit; operand, op and frm outputs come from the command register and stay stable until the FSM leaves WAIT.
  - Units 0-8 (combinational): capture fpu_result and fpu_exc at the end of this cycle. If fpu_illegal is high, err = 01 and data = 0. Go to RESP. Latency from pop to rsp_valid is 2 cycles.
  - Units 9 and 10: go to WAIT and clear the timeout counter.
- WAIT: fpu_valid_in is 0.
  - On the matching done pulse (div for unit 9, sqrt for 10), capture result and exceptions and go to RESP.
  - A non-matching done pulse is ignored.
  - If the counter reaches TIMEOUT-1 with no matching pulse: data 0, exc 0, err 10, go to RESP.
  - A done pulse arriving in the same cycle as the timeout takes precedence over the timeout.
- RESP:
  - rsp_valid holds, and rsp_* stays stable, until rsp_ready is high; then go to IDLE.
  - Back-pressure stalls issue only; queue pushes continue until the queue is full.
- rsp_src always equals the requester id stored with the command.
- fpu_valid_in is one-hot or all-zero in every cycle.
- Reset mid-operation (rst in any state): the queue is flushed and no response is produced. A done pulse arriving after reset is ignored.

Decomposition:
- Shared package fpu_sched_pkg:
  - unit index constants (UNIT_FCLASS = 0 … UNIT_SQRT = 10)
  - a packed command struct typedef
  - err encoding constants
  - FSM state enum
- One sub-module: fpu_cmd_fifo, a parameterised synchronous FIFO with push/pop, full/empty and count. The arbiter and FSM stay in the top level.

Test Plan:
- Req0 sends add (unit 6, op 0, frm 0, a = 0x3F800000, b = 0x40000000); the model drives fpu_result = 0x40400000 -> rsp_valid 2 cycles after pop, data 0x40400000, src 0, err 00.
- Req1 sends div (unit 9, a = 0x40C00000, b = 0x40000000); the model pulses fpu_div_done after 30 cycles with 0x40400000 -> fpu_valid_in = 0x200 for exactly 1 cycle, then rsp data 0x40400000, src 1.
- Div issued and fpu_div_done never pulses -> rsp exactly TIMEOUT cycles after ISSUE, err 10, data 0. A done pulse injected in that same cycle instead gives err 00.
- Both requesters held valid with rsp_ready = 1 -> grants alternate 0,1,0,1; responses return in push order.
- rsp_ready = 0 and DEPTH+2 pushes attempted -> q_count saturates at DEPTH + ... pops as described (the head pops before the first response blocks), req_ready drops when full, no command is lost. Releasing rsp_ready drains every command in FIFO order.
- unit = 12 -> err 01, no fpu_valid_in bit set. Sign-inject (unit 1) with op = 3 and fpu_illegal high -> err 01, data 0.
- rst asserted while in WAIT -> next cycle: FSM IDLE, q_count 0, rsp_valid 0, fpu_valid_in 0.
